csr_timer_bank: RTL and testbench

//  Parametrised multi-channel countdown timer bank, successor to the single

---
 rtl/csr_timer_bank.sv | 133 +++++++++++++
 tb/tb_csr_timer_bank.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_timer_bank.sv
// csr_timer_bank: multi-channel countdown timer bank on the CSR access bus.
// Each channel has CFG/VAL/CLR registers, a counter and a pending bit. A
// global ISTAT/IMASK pair gates pending bits onto timer_irq / timer_any.
// Optional feature macro: TIMER_PRESCALE_EN adds a shared 8-bit prescaler
// (PRESC register at G+2). Without it every cycle is a tick.
module csr_timer_bank #(
    parameter int          N_TIMERS = 2,
    parameter int          CNT_W    = 32,
    parameter logic [13:0] CSR_BASE = 14'h041
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [13:0]         csr_num,
    input  logic                csr_we,
    input  logic [31:0]         csr_wmask,
    input  logic [31:0]         csr_wvalue,
    output logic [31:0]         csr_rvalue,
    output logic [N_TIMERS-1:0] timer_irq,
    output logic                timer_any
);
    localparam logic [13:0]      G_BASE   = CSR_BASE + 14'(4 * N_TIMERS);
    localparam logic [CNT_W-1:0] CNT_ONES = '1;

    logic [CNT_W-1:0]    cfg_q   [N_TIMERS];
    logic [CNT_W-1:0]    cfg_d   [N_TIMERS];
    logic [CNT_W-1:0]    cfg_new [N_TIMERS];
    logic [CNT_W-1:0]    cnt_q   [N_TIMERS];
    logic [CNT_W-1:0]    cnt_d   [N_TIMERS];
    logic [N_TIMERS-1:0] pend_q, pend_d;
    logic [N_TIMERS-1:0] imask_q, imask_d;
    logic [N_TIMERS-1:0] cfg_wr, clr_wr, hit_zero;
    logic                tick;

    function automatic logic [13:0] ch_addr(input int ch, input int off);
        return CSR_BASE + 14'(4 * ch + off);
    endfunction

`ifdef TIMER_PRESCALE_EN
    logic [7:0] presc_q, presc_d;
    logic [7:0] pcnt_q, pcnt_d;

    // Prescaler counts 0..PRESC; a tick is issued while it sits at 0, and a
    // PRESC write restarts it so the very next cycle ticks.
    always_comb begin
        presc_d = presc_q;
        pcnt_d  = (pcnt_q == presc_q) ? 8'd0 : pcnt_q + 8'd1;
        if (csr_we && csr_num == G_BASE + 14'd2) begin
            presc_d = (csr_wmask[7:0] & csr_wvalue[7:0]) | (~csr_wmask[7:0] & presc_q);
            pcnt_d  = 8'd0;
        end
    end

    assign tick = (pcnt_q == 8'd0);

    // Prescaler state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q <= 8'd0;
            pcnt_q  <= 8'd0;
        end else begin
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Per-channel next state: a CFG write that enables the channel reloads the
    // counter regardless of tick; otherwise count on tick until parked at all-ones.
    always_comb begin
        for (int i = 0; i < N_TIMERS; i++) begin
            cfg_wr[i]   = csr_we && (csr_num == ch_addr(i, 0));
            clr_wr[i]   = csr_we && (csr_num == ch_addr(i, 2)) && csr_wmask[0] && csr_wvalue[0];
            hit_zero[i] = cfg_q[i][0] && tick && (cnt_q[i] == '0);
            cfg_new[i]  = (csr_wmask[CNT_W-1:0] & csr_wvalue[CNT_W-1:0])
                        | (~csr_wmask[CNT_W-1:0] & cfg_q[i]);
            cfg_d[i]    = cfg_wr[i] ? cfg_new[i] : cfg_q[i];
            cnt_d[i]    = cnt_q[i];
            if (cfg_wr[i] && cfg_new[i][0]) begin
                cnt_d[i] = {cfg_new[i][CNT_W-1:2], 2'b00};
            end else if (tick && cfg_q[i][0] && cnt_q[i] != CNT_ONES) begin
                if (cnt_q[i] == '0 && cfg_q[i][1])
                    cnt_d[i] = {cfg_q[i][CNT_W-1:2], 2'b00};
                else
                    cnt_d[i] = cnt_q[i] - 1'b1;
            end
            // A set on the same cycle as a clear wins.
            pend_d[i] = hit_zero[i] | (pend_q[i] & ~clr_wr[i]);
        end
        imask_d = imask_q;
        if (csr_we && csr_num == G_BASE + 14'd1)
            imask_d = (csr_wmask[N_TIMERS-1:0] & csr_wvalue[N_TIMERS-1:0])
                    | (~csr_wmask[N_TIMERS-1:0] & imask_q);
    end

    // Channel and global state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N_TIMERS; i++) begin
                cfg_q[i] <= '0;
                cnt_q[i] <= CNT_ONES;
            end
            pend_q  <= '0;
            imask_q <= '0;
        end else begin
            for (int i = 0; i < N_TIMERS; i++) begin
                cfg_q[i] <= cfg_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            pend_q  <= pend_d;
            imask_q <= imask_d;
        end
    end

    // Combinational read mux; CLR, reserved and unmapped addresses read zero.
    always_comb begin
        csr_rvalue = '0;
        for (int i = 0; i < N_TIMERS; i++) begin
            if (csr_num == ch_addr(i, 0)) csr_rvalue[CNT_W-1:0] = cfg_q[i];
            if (csr_num == ch_addr(i, 1)) csr_rvalue[CNT_W-1:0] = cnt_q[i];
        end
        if (csr_num == G_BASE)         csr_rvalue[N_TIMERS-1:0] = pend_q;
        if (csr_num == G_BASE + 14'd1) csr_rvalue[N_TIMERS-1:0] = imask_q;
`ifdef TIMER_PRESCALE_EN
        if (csr_num == G_BASE + 14'd2) csr_rvalue[7:0] = presc_q;
`endif
    end

    assign timer_irq = pend_q & imask_q;
    assign timer_any = |timer_irq;

endmodule

// File: tb/tb_csr_timer_bank.sv
// Scoreboard bench for csr_timer_bank (N_TIMERS=2, CNT_W=32, CSR_BASE=0x041).
// Stimulus pushes expected read data / interrupt values; a negedge monitor
// pops and compares them while the check strobe is active.
module tb_csr_timer_bank;
    localparam logic [13:0] CFG0  = 14'h041;
    localparam logic [13:0] VAL0  = 14'h042;
    localparam logic [13:0] CLR0  = 14'h043;
    localparam logic [13:0] RSV0  = 14'h044;
    localparam logic [13:0] CFG1  = 14'h045;
    localparam logic [13:0] VAL1  = 14'h046;
    localparam logic [13:0] CLR1  = 14'h047;
    localparam logic [13:0] ISTAT = 14'h049;
    localparam logic [13:0] IMASK = 14'h04A;
    localparam logic [13:0] PRESC = 14'h04B;
    localparam logic [31:0] ONES  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        resetn;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic [31:0] csr_rvalue;
    logic [1:0]  timer_irq;
    logic        timer_any;

    csr_timer_bank #(.N_TIMERS(2), .CNT_W(32), .CSR_BASE(14'h041)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .csr_num    (csr_num),
        .csr_we     (csr_we),
        .csr_wmask  (csr_wmask),
        .csr_wvalue (csr_wvalue),
        .csr_rvalue (csr_rvalue),
        .timer_irq  (timer_irq),
        .timer_any  (timer_any)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q [$];
    bit          sel_q [$];
    string       name_q[$];
    logic        chk_v    = 1'b0;
    logic        done_chk = 1'b0;
    int          n_chk    = 0;
    int          n_fail   = 0;
    logic [31:0] m_e;
    bit          m_s;
    string       m_n;

    // Monitor: compares every queued expectation while the check strobe is up.
    always @(negedge clk) begin
        if (chk_v) begin
            while (exp_q.size() > 0) begin
                m_e = exp_q.pop_front();
                m_s = sel_q.pop_front();
                m_n = name_q.pop_front();
                n_chk++;
                if (!m_s) begin
                    if (csr_rvalue !== m_e) begin
                        n_fail++;
                        $display("FAIL %s: rvalue got %h expected %h", m_n, csr_rvalue, m_e);
                    end
                end else begin
                    if ({timer_any, timer_irq} !== {|m_e[1:0], m_e[1:0]}) begin
                        n_fail++;
                        $display("FAIL %s: any/irq got %b/%b expected %b/%b",
                                 m_n, timer_any, timer_irq, |m_e[1:0], m_e[1:0]);
                    end
                end
            end
        end
        if (done_chk) begin
            n_chk++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
        csr_num    = a;
        csr_wvalue = d;
        csr_wmask  = m;
        csr_we     = 1'b1;
        step(1);
        csr_we     = 1'b0;
        csr_wvalue = '0;
        csr_wmask  = '0;
    endtask

    task automatic push_irq(input logic [1:0] e, input string nm);
        exp_q.push_back({30'b0, e});
        sel_q.push_back(1'b1);
        name_q.push_back(nm);
    endtask

    task automatic chk(input logic [13:0] a, input logic [31:0] e, input string nm);
        exp_q.push_back(e);
        sel_q.push_back(1'b0);
        name_q.push_back(nm);
        csr_num = a;
        chk_v   = 1'b1;
        step(1);
        chk_v   = 1'b0;
    endtask

    initial begin
        resetn     = 1'b0;
        csr_num    = '0;
        csr_we     = 1'b0;
        csr_wmask  = '0;
        csr_wvalue = '0;
        step(2);
        resetn = 1'b1;

        // Reset values
        push_irq(2'b00, "reset irq");
        chk(VAL0, ONES, "reset val0");
        chk(CFG0, 32'h0, "reset cfg0");
        chk(VAL1, ONES, "reset val1");

        // Reset mid-count with pending set beforehand
        wr(IMASK, 32'h1, ONES);
        wr(CFG0, 32'h1, ONES);           // load 0
        step(1);                          // 0 -> pending, wraps
        wr(CFG0, 32'h15, ONES);          // load 20
        step(8);                          // 12
        push_irq(2'b01, "pre-reset irq");
        chk(VAL0, 32'd12, "mid-count val0");
        resetn = 1'b0;
        push_irq(2'b00, "async reset irq");
        chk(VAL0, ONES, "async reset val0");
        chk(CFG0, 32'h0, "async reset cfg0");
        chk(IMASK, 32'h0, "async reset imask");
        resetn = 1'b1;

        // One-shot
        wr(IMASK, 32'h1, ONES);
        wr(CFG0, 32'h5, ONES);
        for (int k = 0; k < 5; k++) begin
            push_irq(2'b00, "oneshot irq low");
            chk(VAL0, 32'(4 - k), "oneshot val0");
        end
        push_irq(2'b01, "oneshot irq rise");
        chk(VAL0, ONES, "oneshot wrap");
        chk(ISTAT, 32'h1, "oneshot istat");
        chk(VAL0, ONES, "oneshot hold");
        wr(CLR0, 32'h1, ONES);
        push_irq(2'b00, "oneshot cleared irq");
        chk(ISTAT, 32'h0, "oneshot cleared istat");
        wr(CFG0, 32'h0, ONES);

        // Periodic on channel 1, masked
        wr(IMASK, 32'h0, ONES);
        wr(CFG1, 32'hB, ONES);
        for (int k = 0; k < 18; k++) begin
            push_irq(2'b00, "periodic masked irq");
            chk(VAL1, 32'(8 - (k % 9)), "periodic val1");
        end
        chk(ISTAT, 32'h2, "periodic istat");
        wr(IMASK, 32'h2, ONES);
        push_irq(2'b10, "periodic unmasked irq");
        chk(ISTAT, 32'h2, "periodic istat2");
        wr(CFG1, 32'h0, ONES);           // freezes at 4
        wr(CLR1, 32'h1, ONES);
        push_irq(2'b00, "clr1 irq");
        chk(VAL1, 32'd4, "frozen val1");
        chk(ISTAT, 32'h0, "clr1 istat");

        // Same-cycle set and clear
        wr(IMASK, 32'h3, ONES);
        wr(CFG0, 32'h5, ONES);
        step(4);                          // cnt0 == 0 now
        wr(CLR0, 32'h1, ONES);
        push_irq(2'b01, "set-wins irq");
        chk(ISTAT, 32'h1, "set-wins istat");
        wr(CLR0, 32'h1, 32'h0);
        chk(ISTAT, 32'h1, "clr wmask0 istat");
        wr(CLR0, 32'h1, ONES);
        push_irq(2'b00, "clr irq");
        chk(ISTAT, 32'h0, "clr istat");

        // Masked write, read-only and unmapped addresses
        wr(CFG0, 32'h15, ONES);          // 20
        wr(CFG0, 32'h0, 32'h1);          // decrements to 19, EN off
        chk(CFG0, 32'h14, "masked cfg0");
        chk(VAL0, 32'd19, "frozen val0");
        wr(VAL0, 32'h55, ONES);
        chk(VAL0, 32'd19, "val ro");
        chk(CLR0, 32'h0, "clr reads 0");
        chk(RSV0, 32'h0, "reserved reads 0");
        chk(14'h040, 32'h0, "unmapped below");
        chk(14'h04C, 32'h0, "unmapped above");

`ifdef TIMER_PRESCALE_EN
        wr(PRESC, 32'h3, ONES);
        wr(CFG0, 32'h5, ONES);
        for (int k = 0; k < 9; k++)
            chk(VAL0, 32'(4 - k / 4), "prescaled val0");
        chk(PRESC, 32'h3, "presc readback");
`else
        wr(PRESC, 32'h3, ONES);
        chk(PRESC, 32'h0, "presc absent");
`endif

        done_chk = 1'b1;
        step(1);
        done_chk = 1'b0;
        step(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
